// File: rtl/mulc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mulc_pkg
// Description : Shared constants, state encoding and chunk multiply-add helper
//               for the multiply-by-constant (divide-by-23 inverse) datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mulc_pkg;

    // Constant multiplier and the widths that follow from it
    localparam int DIVISOR_DEF = 23;
    localparam int CHUNK_DEF   = 4;
    localparam int RW_DEF      = 5;
    localparam int PW_DEF      = CHUNK_DEF + RW_DEF + 1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One digit step of the multiply: chunk*DIVISOR + carry at default widths
    function automatic logic [PW_DEF-1:0] chunk_mac(
        input logic [CHUNK_DEF-1:0] chunk,
        input logic [RW_DEF-1:0]    carry
    );
        return PW_DEF'(chunk) * PW_DEF'(DIVISOR_DEF) + PW_DEF'(carry);
    endfunction

endpackage : mulc_pkg
`default_nettype wire

// File: rtl/mulc_chunk_step.sv
`default_nettype none
// ============================================================================
// Module      : mulc_chunk_step
// Description : Combinational digit step p = chunk*DIVISOR + carry, split into
//               the emitted result digit and the carry into the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module mulc_chunk_step #(
    parameter int CHUNK   = 4,
    parameter int RW      = 5,
    parameter int DIVISOR = 23
) (
    input  logic [CHUNK-1:0] chunk_i,
    input  logic [RW-1:0]    carry_i,
    output logic [CHUNK-1:0] digit_o,
    output logic [RW-1:0]    carry_out_o,
    output logic             ovf_o
);

    localparam int PW = CHUNK + RW + 1;

    logic [PW-1:0] w_p;

    // Full-precision product plus incoming carry
    always_comb begin
        w_p         = PW'(chunk_i) * PW'(DIVISOR) + PW'(carry_i);
        digit_o     = w_p[CHUNK-1:0];
        carry_out_o = w_p[CHUNK+RW-1:CHUNK];
        // Carry stays below DIVISOR, so this top bit is a guard that never
        // fires for legal parameters; it is folded into the error flag.
        ovf_o       = w_p[PW-1];
    end

endmodule : mulc_chunk_step
`default_nettype wire

// File: rtl/mul_const_23_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_const_23_seq
// Description : Sequential x = q*DIVISOR + r reconstruction, CHUNK quotient
//               bits per cycle LSB-first, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_const_23_seq
    import mulc_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int CHUNK   = CHUNK_DEF,
    parameter int RW      = RW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_q,
    input  logic [RW-1:0]    in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic             out_err
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NSTEP - 1);
    localparam logic [RW-1:0]   DIV_RW   = RW'(DIVISOR);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  qsr_q,   qsr_d;
    logic [WIDTH-1:0]  xsr_q,   xsr_d;
    logic [RW-1:0]     carry_q, carry_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic              rerr_q,  rerr_d;
    logic [WIDTH-1:0]  outx_q,  outx_d;
    logic              oerr_q,  oerr_d;

    logic [CHUNK-1:0]  w_digit;
    logic [RW-1:0]     w_carry_next;
    logic              w_step_ovf;

    mulc_chunk_step #(
        .CHUNK   (CHUNK),
        .RW      (RW),
        .DIVISOR (DIVISOR)
    ) u_step (
        .chunk_i     (qsr_q[CHUNK-1:0]),
        .carry_i     (carry_q),
        .digit_o     (w_digit),
        .carry_out_o (w_carry_next),
        .ovf_o       (w_step_ovf)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qsr_q   <= '0;
            xsr_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
            outx_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qsr_q   <= qsr_d;
            xsr_q   <= xsr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            rerr_q  <= rerr_d;
            outx_q  <= outx_d;
            oerr_q  <= oerr_d;
        end
    end

    // Next-state, datapath update and result capture
    always_comb begin
        state_d = state_q;
        qsr_d   = qsr_q;
        xsr_d   = xsr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
        outx_d  = outx_q;
        oerr_d  = oerr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    qsr_d   = in_q;
                    xsr_d   = '0;
                    carry_d = in_r;
                    // Out-of-range remainder is still folded in arithmetically
                    rerr_d  = (in_r >= DIV_RW);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                qsr_d   = qsr_q >> CHUNK;
                xsr_d   = {w_digit, xsr_q[WIDTH-1:CHUNK]};
                carry_d = w_carry_next;
                rerr_d  = rerr_q | w_step_ovf;
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Result registers only change here, so they hold across
                    // the handshake and the following operation's RUN phase.
                    outx_d  = xsr_d;
                    oerr_d  = rerr_d | (carry_d != '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_x     = outx_q;
        out_err   = oerr_q;
    end

endmodule : mul_const_23_seq
`default_nettype wire

// File: tb/tb_mul_const_23_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_const_23_seq
// Description : Self-checking bench for mul_const_23_seq: directed table,
//               randomized operands against a wide-arithmetic model, and
//               back-pressure / mid-run reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_const_23_seq;

    localparam int WIDTH = 64;
    localparam int RW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_q;
    logic [RW-1:0]    in_r;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic             out_err;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [63:0] q;
        logic [4:0]  r;
        logic [63:0] x;
        logic        err;
    } vec_t;

    mul_const_23_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, got, exp);
        end
    endtask

    // Reference: exact 128-bit arithmetic, then wrap and flag overflow
    task automatic model(input logic [63:0] q, input logic [4:0] r,
                         output logic [63:0] x, output logic err);
        logic [127:0] full;
        full = {64'd0, q} * 128'd23 + {123'd0, r};
        x    = full[63:0];
        err  = (r >= 5'd23) || (full[127:64] != 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand and wait for the result. lat counts posedges from
    // and including the accept edge up to the first one showing out_valid.
    task automatic run_op(input logic [63:0] q, input logic [4:0] r,
                          output logic [63:0] x, output logic err,
                          output int lat);
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_q     = q;
        in_r     = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_q     = {$urandom, $urandom};
        in_r     = 5'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid)
            check("out_valid_timeout", 64'd0, 64'd1);
        x   = out_x;
        err = out_err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [63:0] gx, ex, q;
        logic        ge, ee;
        logic [4:0]  r;
        int          lat;

        vecs[0] = '{q: 64'd0,                  r: 5'd0,  x: 64'd0,                  err: 1'b0};
        vecs[1] = '{q: 64'd1,                  r: 5'd5,  x: 64'd28,                 err: 1'b0};
        vecs[2] = '{q: 64'd802032351030850070, r: 5'd5,  x: 64'hFFFFFFFFFFFFFFFF,   err: 1'b0};
        vecs[3] = '{q: 64'd802032351030850071, r: 5'd0,  x: 64'd17,                 err: 1'b1};
        vecs[4] = '{q: 64'd2,                  r: 5'd23, x: 64'd69,                 err: 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_q = '0; in_r = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_x",     out_x,              64'd0);
        check("reset_out_err",   {63'd0, out_err},   64'd0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].q, vecs[i].r, gx, ge, lat);
            check($sformatf("vec%0d_x", i),   gx,            vecs[i].x);
            check($sformatf("vec%0d_err", i), {63'd0, ge},   {63'd0, vecs[i].err});
            check($sformatf("vec%0d_lat", i), 64'(lat),      64'd17);
            check($sformatf("vec%0d_drop", i), {63'd0, out_valid}, 64'd0);
            check($sformatf("vec%0d_hold", i), out_x,        vecs[i].x);
        end

        // Randomized operands, mixing in-range and overflowing quotients
        for (int i = 0; i < 40; i++) begin
            q = {$urandom, $urandom} >> $urandom_range(0, 8);
            r = 5'($urandom_range(0, 31));
            model(q, r, ex, ee);
            run_op(q, r, gx, ge, lat);
            check($sformatf("rand%0d_x", i),   gx,          ex);
            check($sformatf("rand%0d_err", i), {63'd0, ge}, {63'd0, ee});
        end

        // Back-pressure: DONE held for 10 cycles, stray in_valid ignored
        in_q = 64'd100; in_r = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d_x", i),     out_x,              64'd2303);
            check($sformatf("bp%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp%0d_ready", i), {63'd0, in_ready},  64'd0);
            in_valid = i[0];
            in_q     = 64'd7;
            in_r     = 5'd1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drop_valid", {63'd0, out_valid}, 64'd0);
        check("bp_hold_x",     out_x,              64'd2303);
        tick();
        check("bp_no_accept",  {63'd0, in_ready},  64'd1);

        // Reset in cycle 8 of RUN aborts the operation
        in_q = 64'hFFFF_FFFF_FFFF_FFFF; in_r = 5'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_out_x",     out_x,              64'd0);
        repeat (20) tick();
        check("abort_stays_idle", {63'd0, out_valid}, 64'd0);
        run_op(64'd3, 5'd1, gx, ge, lat);
        check("after_abort_x",   gx,          64'd70);
        check("after_abort_err", {63'd0, ge}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_mul_const_23_seq
`default_nettype wire

// File: doc/mul_const_23_seq.md
Name: mul_const_23_seq

Overview:
- Inverse of the divide-by-23 datapath. Reconstructs the dividend x = q*DIVISOR + r from a quotient and remainder.
- Processes CHUNK quotient bits per cycle, least significant chunk first, with a small carry register.
- Sits after the constant divider as a round-trip checker and as a standalone multiply-accumulate by the constant.
- Uses valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 64: width of the quotient and the reconstructed dividend. Must be a multiple of CHUNK.
- DIVISOR, 23: constant multiplier. Must satisfy 2 <= DIVISOR < 2^CHUNK*2.
- CHUNK, 4: quotient bits consumed per cycle.
- RW, 5: remainder/carry width, equal to clog2(DIVISOR).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input operand valid.
- in_ready, out, 1: block can accept an operand.
- in_q, in, WIDTH: quotient.
- in_r, in, RW: remainder.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_x, out, WIDTH: reconstructed dividend, modulo 2^WIDTH.
- out_err, out, 1: set when in_r >= DIVISOR or when the product overflows WIDTH bits.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_x=0, out_err=0, carry=0, chunk counter=0. Reset during RUN or DONE aborts the operation and discards the result.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch in_q into the shift register qsr;
    - carry <= in_r;
    - rerr <= (in_r >= DIVISOR);
    - cnt <= 0;
    - go to RUN.
  - RUN: in_ready=0. Each cycle:
    - p = qsr[CHUNK-1:0]*DIVISOR + carry, width CHUNK+RW+1;
    - result shift register xsr shifts right by CHUNK, inserting p[CHUNK-1:0] at the top;
    - carry <= p >> CHUNK;
    - qsr >>= CHUNK;
    - cnt++.
    - After WIDTH/CHUNK cycles go to DONE.
    - Carry invariant: carry < DIVISOR always holds. Worst case is (15*23+22)>>4 = 22, so RW bits suffice and never overflow.
  - DONE:
    - out_valid=1, out_x=xsr;
    - out_err = rerr | (carry != 0), i.e. a final nonzero carry means overflow.
    - Outputs hold stable while out_ready=0.
    - On out_ready go to IDLE the next cycle, with out_valid=0.
- Latency: the accept edge, then WIDTH/CHUNK RUN cycles (16 by default). out_valid rises in the cycle after the last RUN cycle. Throughput is one operation per WIDTH/CHUNK+2 cycles minimum.
- in_ready is asserted only in IDLE. There is no back-to-back acceptance while DONE is held.
- in_r >= DIVISOR is still computed arithmetically, so out_x = q*DIVISOR + r mod 2^WIDTH, with out_err=1.
- out_x and out_err are registered and keep their values after the handshake until the next DONE. Only out_valid drops.
- in_q and in_r are sampled only on the accept edge. Changes during RUN are ignored.

Decomposition:
- Shared package mulc_pkg holds:
  - the DIVISOR constant and RW;
  - the CHUNK default;
  - the state enum {IDLE, RUN, DONE};
  - a function computing chunk*DIVISOR + carry.
- One natural sub-module, mulc_chunk_step: combinational p = chunk*DIVISOR + carry, with outputs digit[CHUNK-1:0] and carry_out[RW-1:0]. The top level holds the FSM, the shift registers and the handshakes.

Test Plan:
- q=0, r=0 -> out_x=0, out_err=0. out_valid rises exactly 17 cycles after the accept edge.
- q=1, r=5 -> out_x=28 (0x1C), out_err=0.
- q=802032351030850070, r=5 -> out_x=0xFFFFFFFFFFFFFFFF, out_err=0 (max dividend round trip).
- Overflow and invalid remainder:
  - q=802032351030850071, r=0 -> out_x=17, out_err=1 (overflow).
  - q=2, r=23 -> out_x=69, out_err=1 (invalid remainder).
- Back-pressure: hold out_ready=0 for 10 cycles in DONE with q=100, r=3.
  - out_x=2303 stays stable, out_valid=1, in_ready=0.
  - in_valid pulses in this window are not accepted.
- Assert rst at cycle 8 of RUN -> next cycle in_ready=1, out_valid=0, out_x=0. A following q=3, r=1 yields out_x=70.
